// File: rtl/m_wishbone_regbank.sv
// m_wishbone_regbank: a bank of NREG general-purpose registers on a Wishbone
// classic slave port. It supports byte-lane writes, optional wait states and
// transfer abort. It also has a one-cycle write strobe per register and a flat
// export of all registers for peripherals.
module m_wishbone_regbank #(
  parameter int            NREG       = 4,
  parameter int            DW         = 32,
  parameter int            WAITSTATES = 0,
  parameter logic [DW-1:0] RESETVAL   = '0,
  localparam int           AW         = $clog2(NREG),
  localparam int           SW         = DW / 8
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  input  logic [AW-1:0]        ADR_I,
  input  logic [SW-1:0]        SEL_I,
  input  logic [DW-1:0]        DAT_I,
  output logic                 ACK_O,
  output logic [DW-1:0]        DAT_O,
  output logic [NREG-1:0]      wrpulse_o,
  output logic [NREG*DW-1:0]   regs_o
);

  localparam int         WINIT_I = (WAITSTATES > 0) ? WAITSTATES - 1 : 0;
  localparam logic [2:0] WINIT   = 3'(WINIT_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         wcnt_q, wcnt_d;
  logic               commit;
  logic [DW-1:0]      regs_q [NREG];
  logic [DW-1:0]      dat_q;
  logic [NREG-1:0]    wrpulse_q;
  logic [NREG-1:0]    adr_onehot;

  // Next-state logic: count down the wait states, abort if the strobe drops,
  // and always return to IDLE after a single ACK cycle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (STB_I) begin
          if (WAITSTATES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WINIT;
          end
        end
      end
      ST_WAIT: begin
        if (!STB_I) begin
          state_d = ST_IDLE;
          wcnt_d  = 3'd0;
        end else if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 3'd0;
      end
    endcase
  end

  // The transfer commits on the edge that enters ACK.
  assign commit = (state_q != ST_ACK) && (state_d == ST_ACK);

  // Decode the register index into a one-hot vector for the write strobes.
  always_comb begin
    adr_onehot        = '0;
    adr_onehot[ADR_I] = 1'b1;
  end

  // State register and wait counter. Reset overrides a transfer in progress.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Register bank: byte-lane write at the commit edge. Unselected lanes hold.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= RESETVAL;
      end
    end else if (commit && WE_I) begin
      for (int b = 0; b < SW; b++) begin
        if (SEL_I[b]) begin
          regs_q[ADR_I][8*b +: 8] <= DAT_I[8*b +: 8];
        end
      end
    end
  end

  // Registered read data and write strobes. Both are non-zero only during
  // the ACK cycle that follows the commit edge.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      dat_q     <= '0;
      wrpulse_q <= '0;
    end else begin
      dat_q     <= (commit && !WE_I) ? regs_q[ADR_I] : '0;
      wrpulse_q <= (commit && WE_I) ? adr_onehot : '0;
    end
  end

  assign ACK_O     = (state_q == ST_ACK);
  assign DAT_O     = dat_q;
  assign wrpulse_o = wrpulse_q;

  // Flatten the register array for peripherals.
  for (genvar i = 0; i < NREG; i++) begin : g_export
    assign regs_o[i*DW +: DW] = regs_q[i];
  end

endmodule

// File: tb/tb_m_wishbone_regbank.sv
// tb_m_wishbone_regbank: scoreboard bench for m_wishbone_regbank. It uses four
// instances, each with a different parameter set. The bench pushes the
// expected result of each transfer when it drives the transfer. It pops and
// compares that result when ACK_O arrives.
module tb_m_wishbone_regbank;

  localparam logic [31:0] RV0 = 32'hA5A5_0000;
  localparam logic [31:0] RV3 = 32'h1357_9BDF;
  localparam logic [31:0] RV2 = 32'h2468_ACE0;
  localparam logic [7:0]  RV8 = 8'h3C;

  typedef struct packed {
    logic [31:0] dat;
    logic [15:0] wp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  adr   = '0;
  logic [3:0]  sel   = '0;
  logic [31:0] dat   = '0;
  int          cur   = 0;

  logic         stb0, stb3, stb2, stb8;
  logic         ack0, ack3, ack2, ack8;
  logic [31:0]  dato0, dato3, dato2;
  logic [7:0]   dato8;
  logic [3:0]   wp0, wp3, wp2;
  logic [15:0]  wp8;
  logic [127:0] regs0, regs3, regs2, regs8;

  logic         obs_ack;
  logic [31:0]  obs_dat;
  logic [15:0]  obs_wp;
  logic [127:0] obs_regs;

  assign stb0 = stb && (cur == 0);
  assign stb3 = stb && (cur == 3);
  assign stb2 = stb && (cur == 2);
  assign stb8 = stb && (cur == 8);

  // Free-running clock
  always #5 clk = ~clk;

  m_wishbone_regbank #(.NREG(4), .DW(32), .WAITSTATES(0), .RESETVAL(RV0)) dut0 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb0), .WE_I(we), .ADR_I(adr[1:0]),
    .SEL_I(sel), .DAT_I(dat), .ACK_O(ack0), .DAT_O(dato0),
    .wrpulse_o(wp0), .regs_o(regs0));

  m_wishbone_regbank #(.NREG(4), .DW(32), .WAITSTATES(3), .RESETVAL(RV3)) dut3 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb3), .WE_I(we), .ADR_I(adr[1:0]),
    .SEL_I(sel), .DAT_I(dat), .ACK_O(ack3), .DAT_O(dato3),
    .wrpulse_o(wp3), .regs_o(regs3));

  m_wishbone_regbank #(.NREG(4), .DW(32), .WAITSTATES(2), .RESETVAL(RV2)) dut2 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb2), .WE_I(we), .ADR_I(adr[1:0]),
    .SEL_I(sel), .DAT_I(dat), .ACK_O(ack2), .DAT_O(dato2),
    .wrpulse_o(wp2), .regs_o(regs2));

  m_wishbone_regbank #(.NREG(16), .DW(8), .WAITSTATES(0), .RESETVAL(RV8)) dut8 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb8), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel[0:0]), .DAT_I(dat[7:0]), .ACK_O(ack8), .DAT_O(dato8),
    .wrpulse_o(wp8), .regs_o(regs8));

  // Select the outputs of the instance that is currently addressed.
  always_comb begin
    obs_ack  = 1'b0;
    obs_dat  = '0;
    obs_wp   = '0;
    obs_regs = '0;
    case (cur)
      0: begin obs_ack = ack0; obs_dat = dato0; obs_wp = {12'd0, wp0}; obs_regs = regs0; end
      3: begin obs_ack = ack3; obs_dat = dato3; obs_wp = {12'd0, wp3}; obs_regs = regs3; end
      2: begin obs_ack = ack2; obs_dat = dato2; obs_wp = {12'd0, wp2}; obs_regs = regs2; end
      8: begin obs_ack = ack8; obs_dat = {24'd0, dato8}; obs_wp = wp8; obs_regs = regs8; end
      default: ;
    endcase
  end

  // Drive one transfer on instance 'which' and wait a bounded time for ACK.
  // Returns lat = -1 if ACK never arrives.
  task automatic xfer(input int which, input logic w, input logic [3:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output int lat, output logic [31:0] rd,
                      output logic [15:0] wp, output logic [127:0] rg);
    @(negedge clk);
    cur = which; we = w; adr = a; sel = s; dat = d; stb = 1'b1;
    lat = -1; rd = '0; wp = '0; rg = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (obs_ack) begin
        lat = c; rd = obs_dat; wp = obs_wp; rg = obs_regs;
      end
    end
    stb = 1'b0;
  endtask

  // Reset values, strobe ignored while reset is held, then reads of all regs.
  task automatic test_reset();
    int lat; logic [31:0] rd; logic [15:0] wp; logic [127:0] rg; exp_t e;
    rst_n = 1'b0; stb = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ack: got %b, expected 0", ack0); end
    vectors++; if (dato0 !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_dat: got %h, expected 0", dato0); end
    vectors++; if (wp0 !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_wp: got %b, expected 0", wp0); end
    vectors++; if (regs0 !== {4{RV0}}) begin miscompares++; $display("[TB] FAIL rst_regs: got %h, expected %h", regs0, {4{RV0}}); end
    vectors++; if (regs8 !== {16{RV8}}) begin miscompares++; $display("[TB] FAIL rst_regs8: got %h, expected %h", regs8, {16{RV8}}); end
    cur = 0; we = 1'b0; adr = 4'd1; stb = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL stb_in_reset: got %b, expected 0", ack0); end
    @(negedge clk);
    vectors++; if (ack0 !== 1'b1) begin miscompares++; $display("[TB] FAIL first_accept: got %b, expected 1", ack0); end
    vectors++; if (dato0 !== RV0) begin miscompares++; $display("[TB] FAIL first_dat: got %h, expected %h", dato0, RV0); end
    stb = 1'b0;
    @(negedge clk);
    vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL ack_one_cycle: got %b, expected 0", ack0); end
    for (int a = 0; a < 4; a++) sb.push_back('{dat: RV0, wp: 16'h0});
    for (int a = 0; a < 4; a++) begin
      xfer(0, 1'b0, 4'(a), 4'h0, 32'h0, lat, rd, wp, rg);
      e = sb.pop_front();
      vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL rd%0d_lat: got %0d, expected 1", a, lat); end
      vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL rd%0d_dat: got %h, expected %h", a, rd, e.dat); end
      vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL rd%0d_wp: got %h, expected %h", a, wp, e.wp); end
    end
  endtask

  // Full write followed by a partial byte-lane write to reg2.
  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic [15:0] wp; logic [127:0] rg; exp_t e;
    sb.push_back('{dat: 32'h0, wp: 16'h0004});
    xfer(0, 1'b1, 4'd2, 4'hF, 32'h1122_3344, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL bl_w1_lat: got %0d, expected 1", lat); end
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL bl_w1_dat: got %h, expected %h", rd, e.dat); end
    vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL bl_w1_wp: got %h, expected %h", wp, e.wp); end
    vectors++; if (rg[95:64] !== 32'h1122_3344) begin miscompares++; $display("[TB] FAIL bl_w1_regs: got %h, expected 11223344", rg[95:64]); end
    sb.push_back('{dat: 32'h0, wp: 16'h0004});
    xfer(0, 1'b1, 4'd2, 4'b0101, 32'hFFFF_FFFF, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL bl_w2_wp: got %h, expected %h", wp, e.wp); end
    vectors++; if (rg[95:64] !== 32'h11FF_33FF) begin miscompares++; $display("[TB] FAIL bl_w2_regs: got %h, expected 11ff33ff", rg[95:64]); end
    vectors++; if (rg[31:0] !== RV0) begin miscompares++; $display("[TB] FAIL bl_reg0_kept: got %h, expected %h", rg[31:0], RV0); end
    @(negedge clk);
    vectors++; if (wp0 !== 4'd0) begin miscompares++; $display("[TB] FAIL bl_wp_one_cycle: got %b, expected 0", wp0); end
    sb.push_back('{dat: 32'h11FF_33FF, wp: 16'h0});
    xfer(0, 1'b0, 4'd2, 4'h0, 32'h0, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL bl_rd_dat: got %h, expected %h", rd, e.dat); end
    vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL bl_rd_wp: got %h, expected %h", wp, e.wp); end
  endtask

  // Three wait states with STB_I held: ACK in cycle 4, then one idle cycle,
  // then the next ACK five cycles later.
  task automatic test_wait_hold();
    int first, second; logic ack_after; exp_t e;
    first = -1; second = -1; ack_after = 1'b1;
    sb.push_back('{dat: RV3, wp: 16'h0});
    sb.push_back('{dat: RV3, wp: 16'h0});
    @(negedge clk);
    cur = 3; we = 1'b0; adr = 4'd0; sel = 4'h0; stb = 1'b1;
    for (int c = 1; c <= 30 && second < 0; c++) begin
      @(negedge clk);
      if (obs_ack) begin
        e = sb.pop_front();
        vectors++; if (obs_dat !== e.dat) begin miscompares++; $display("[TB] FAIL ws_dat: got %h, expected %h", obs_dat, e.dat); end
        if (first < 0) first = c; else second = c;
      end
      if (first > 0 && c == first + 1) ack_after = obs_ack;
    end
    stb = 1'b0;
    vectors++; if (first !== 4) begin miscompares++; $display("[TB] FAIL ws_first_ack: got %0d, expected 4", first); end
    vectors++; if (ack_after !== 1'b0) begin miscompares++; $display("[TB] FAIL ws_gap: got %b, expected 0", ack_after); end
    vectors++; if (second !== 9) begin miscompares++; $display("[TB] FAIL ws_second_ack: got %0d, expected 9", second); end
    sb.delete();
  endtask

  // Abort a write by dropping STB_I after two wait cycles.
  task automatic test_abort();
    int lat; logic [31:0] rd; logic [15:0] wp; logic [127:0] rg; exp_t e;
    logic seen_ack, seen_wp;
    seen_ack = 1'b0; seen_wp = 1'b0;
    @(negedge clk);
    cur = 3; we = 1'b1; adr = 4'd1; sel = 4'hF; dat = 32'hDEAD_BEEF; stb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen_ack |= obs_ack; seen_wp |= (obs_wp != 16'h0);
    end
    stb = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_ack |= obs_ack; seen_wp |= (obs_wp != 16'h0);
    end
    vectors++; if (seen_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ack: got %b, expected 0", seen_ack); end
    vectors++; if (seen_wp !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_wp: got %b, expected 0", seen_wp); end
    vectors++; if (regs3[63:32] !== RV3) begin miscompares++; $display("[TB] FAIL abort_reg1: got %h, expected %h", regs3[63:32], RV3); end
    sb.push_back('{dat: RV3, wp: 16'h0});
    xfer(3, 1'b0, 4'd1, 4'h0, 32'h0, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL abort_rd_lat: got %0d, expected 4", lat); end
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL abort_rd_dat: got %h, expected %h", rd, e.dat); end
  endtask

  // Reset asserted while a write is waiting, then normal transfers resume.
  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic [15:0] wp; logic [127:0] rg; exp_t e;
    sb.push_back('{dat: 32'h0, wp: 16'h0008});
    xfer(2, 1'b1, 4'd3, 4'hF, 32'h55AA_55AA, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL rmw_pre_lat: got %0d, expected 3", lat); end
    vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL rmw_pre_wp: got %h, expected %h", wp, e.wp); end
    @(negedge clk);
    cur = 2; we = 1'b1; adr = 4'd0; sel = 4'hF; dat = 32'hCAFE_F00D; stb = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (ack2 !== 1'b0) begin miscompares++; $display("[TB] FAIL rmw_ack: got %b, expected 0", ack2); end
    vectors++; if (wp2 !== 4'd0) begin miscompares++; $display("[TB] FAIL rmw_wp: got %b, expected 0", wp2); end
    vectors++; if (regs2 !== {4{RV2}}) begin miscompares++; $display("[TB] FAIL rmw_regs: got %h, expected %h", regs2, {4{RV2}}); end
    stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{dat: RV2, wp: 16'h0});
    xfer(2, 1'b0, 4'd3, 4'h0, 32'h0, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL rmw_post_lat: got %0d, expected 3", lat); end
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL rmw_post_rd3: got %h, expected %h", rd, e.dat); end
    sb.push_back('{dat: 32'h0, wp: 16'h0001});
    xfer(2, 1'b1, 4'd0, 4'hF, 32'hCAFE_F00D, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL rmw_post_wp: got %h, expected %h", wp, e.wp); end
    sb.push_back('{dat: 32'hCAFE_F00D, wp: 16'h0});
    xfer(2, 1'b0, 4'd0, 4'h0, 32'h0, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL rmw_post_rd0: got %h, expected %h", rd, e.dat); end
  endtask

  // Byte-wide bank with 16 registers: a SEL_I=0 write strobes but does not
  // modify. A SEL_I=1 write lands.
  task automatic test_dw8();
    int lat; logic [31:0] rd; logic [15:0] wp; logic [127:0] rg; exp_t e;
    sb.push_back('{dat: 32'h0, wp: 16'h8000});
    xfer(8, 1'b1, 4'd15, 4'h0, 32'h0000_005A, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL dw8_w_lat: got %0d, expected 1", lat); end
    vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL dw8_w_wp: got %h, expected %h", wp, e.wp); end
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL dw8_w_dat: got %h, expected %h", rd, e.dat); end
    vectors++; if (rg[127:120] !== RV8) begin miscompares++; $display("[TB] FAIL dw8_reg15: got %h, expected %h", rg[127:120], RV8); end
    sb.push_back('{dat: {24'd0, RV8}, wp: 16'h0});
    xfer(8, 1'b0, 4'd15, 4'h0, 32'h0, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL dw8_rd15: got %h, expected %h", rd, e.dat); end
    sb.push_back('{dat: 32'h0, wp: 16'h0080});
    xfer(8, 1'b1, 4'd7, 4'h1, 32'h0000_005A, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (wp !== e.wp) begin miscompares++; $display("[TB] FAIL dw8_w7_wp: got %h, expected %h", wp, e.wp); end
    vectors++; if (rg[63:56] !== 8'h5A) begin miscompares++; $display("[TB] FAIL dw8_reg7: got %h, expected 5a", rg[63:56]); end
    sb.push_back('{dat: 32'h0000_005A, wp: 16'h0});
    xfer(8, 1'b0, 4'd7, 4'h0, 32'h0, lat, rd, wp, rg);
    e = sb.pop_front();
    vectors++; if (rd !== e.dat) begin miscompares++; $display("[TB] FAIL dw8_rd7: got %h, expected %h", rd, e.dat); end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_byte_lanes();
    test_wait_hold();
    test_abort();
    test_reset_mid_wait();
    test_dw8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
